// File: rtl/wave_param_loader.sv
// Command front end for the two-channel wave generator: decodes write/commit bytes into shadows
// and applies all shadows to the packed parameter buses at once. Optional ACK echo: WAVE_PARAM_LOADER_ECHO_EN.
module wave_param_loader #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [31:0] amps,
    output logic [31:0]        offsets,
    output logic [31:0]        phasewords,
    output logic               pending,
    output logic               cmd_err,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA_HI = 3'd1,
        ST_DATA_LO = 3'd2,
`ifdef WAVE_PARAM_LOADER_ECHO_EN
        ST_ECHO    = 3'd4,
`endif
        ST_APPLY   = 3'd3
    } state_t;

    // Write command: 8'b10ff_000c with ff in {00,01,10}
    function automatic logic is_write(input logic [7:0] b);
        return (b[7:6] == 2'b10) && (b[5:4] != 2'b11) && (b[3:1] == 3'b000);
    endfunction

    function automatic logic [31:0] merge_half(input logic [31:0] cur, input logic chan,
                                               input logic [15:0] val);
        return chan ? {val, cur[15:0]} : {cur[31:16], val};
    endfunction

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r;
    logic [1:0]     field_r;
    logic           chan_r;
    logic [7:0]     hi_r;
    logic [31:0]    amp_sh_r, off_sh_r, pw_sh_r;
    logic [31:0]    amps_r, offsets_r, phasewords_r;
    logic           pending_r, cmd_err_r, in_ready_r;
    logic           accept_s, in_packet_s, timeout_s, err_s, wr_s, apply_s;

    assign accept_s    = in_valid & in_ready_r;
    assign in_packet_s = (state_r == ST_DATA_HI) || (state_r == ST_DATA_LO);
    assign timeout_s   = in_packet_s && !accept_s && (cnt_r == CW'(TIMEOUT_CYCLES - 1));

    // Next-state decode and one-cycle action strobes
    always_comb begin
        state_s = state_r;
        err_s   = 1'b0;
        wr_s    = 1'b0;
        apply_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_write(in_data)) begin
                        state_s = ST_DATA_HI;
                    end else if (in_data == 8'hC0) begin
                        state_s = ST_APPLY;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA_HI: begin
                if (accept_s) begin
                    state_s = ST_DATA_LO;
                end else if (timeout_s) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_DATA_HI;
                end
            end
            ST_DATA_LO: begin
                if (accept_s) begin
                    state_s = ST_IDLE;
                    wr_s    = 1'b1;
                end else if (timeout_s) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_DATA_LO;
                end
            end
            ST_APPLY: begin
                apply_s = 1'b1;
`ifdef WAVE_PARAM_LOADER_ECHO_EN
                state_s = ST_ECHO;
`else
                state_s = ST_IDLE;
`endif
            end
`ifdef WAVE_PARAM_LOADER_ECHO_EN
            ST_ECHO: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ECHO;
                end
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // State, packet context, timeout counter and handshake/error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            field_r    <= 2'b00;
            chan_r     <= 1'b0;
            hi_r       <= 8'h00;
            cmd_err_r  <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            cmd_err_r  <= err_s;
            in_ready_r <= (state_s == ST_IDLE) || (state_s == ST_DATA_HI) || (state_s == ST_DATA_LO);
            if (accept_s || !in_packet_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (accept_s && (state_r == ST_IDLE)) begin
                field_r <= in_data[5:4];
                chan_r  <= in_data[0];
            end
            if (accept_s && (state_r == ST_DATA_HI)) begin
                hi_r <= in_data;
            end
        end
    end

    // Shadow writes and the simultaneous commit of all shadows to the outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            amp_sh_r     <= 32'h0000_0000;
            off_sh_r     <= 32'h0000_0000;
            pw_sh_r      <= 32'h0000_0000;
            amps_r       <= 32'h0000_0000;
            offsets_r    <= 32'h0000_0000;
            phasewords_r <= 32'h0000_0000;
            pending_r    <= 1'b0;
        end else begin
            if (wr_s) begin
                case (field_r)
                    2'b00:   amp_sh_r <= merge_half(amp_sh_r, chan_r, {hi_r, in_data});
                    2'b01:   off_sh_r <= merge_half(off_sh_r, chan_r, {hi_r, in_data});
                    2'b10:   pw_sh_r  <= merge_half(pw_sh_r,  chan_r, {hi_r, in_data});
                    default: amp_sh_r <= amp_sh_r;
                endcase
            end
            if (apply_s) begin
                amps_r       <= amp_sh_r;
                offsets_r    <= off_sh_r;
                phasewords_r <= pw_sh_r;
                pending_r    <= 1'b0;
            end else if (wr_s) begin
                pending_r    <= 1'b1;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign amps       = amps_r;
    assign offsets    = offsets_r;
    assign phasewords = phasewords_r;
    assign pending    = pending_r;
    assign cmd_err    = cmd_err_r;

`ifdef WAVE_PARAM_LOADER_ECHO_EN
    logic       out_valid_r;
    logic [7:0] out_data_r;

    // Echo register: valid and ACK byte held for the whole ECHO state
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
        end else begin
            out_valid_r <= (state_s == ST_ECHO);
            out_data_r  <= (state_s == ST_ECHO) ? ACK_BYTE : 8'h00;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
`else
    logic unused_out_ready_s;
    assign unused_out_ready_s = out_ready;
    assign out_valid          = 1'b0;
    assign out_data           = 8'h00;
`endif

endmodule

// File: tb/tb_wave_param_loader.sv
// Directed self-checking bench for wave_param_loader; follows WAVE_PARAM_LOADER_ECHO_EN when defined.
module tb_wave_param_loader;

    localparam int TO = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [7:0]         in_data = 8'h00;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] amps;
    logic [31:0]        offsets, phasewords;
    logic               pending, cmd_err;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    int base;

    wave_param_loader #(.TIMEOUT_CYCLES(TO), .ACK_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .amps(amps), .offsets(offsets), .phasewords(phasewords), .pending(pending),
        .cmd_err(cmd_err), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Count high cycles of the error pulse away from the active edge
    always @(negedge clk) if (!reset && cmd_err) err_pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte and return just after the edge that accepted it
    task automatic send_byte(input logic [7:0] b);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        check("rst_amps", amps, 32'h0);
        check("rst_offsets", offsets, 32'h0);
        check("rst_phasewords", phasewords, 32'h0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Phaseword ch0 (command 8'b1010_0000)
        send_byte(8'hA0); send_byte(8'h00); send_byte(8'h40);
        check("pw_pending_set", 32'(pending), 32'd1);
        check("pw_not_yet", phasewords, 32'h0);
        send_byte(8'hC0);
        check("apply_in_ready", 32'(in_ready), 32'd0);
        check("pw_before_apply_edge", phasewords, 32'h0);
        tick();
        check("pw_applied", phasewords, 32'h0000_0040);
        check("pw_pending_clr", 32'(pending), 32'd0);
        check("pw_amps_zero", amps, 32'h0);
        check("pw_offsets_zero", offsets, 32'h0);

        // Both amplitude halves land on the same edge
        send_byte(8'h81); send_byte(8'h7F); send_byte(8'hFF);
        send_byte(8'h80); send_byte(8'h80); send_byte(8'h00);
        send_byte(8'hC0);
        check("amps_before", amps, 32'h0);
        tick();
        check("amps_both", amps, 32'h7FFF_8000);

        // Timeout after high byte of an offset ch1 write
        base = err_pulses;
        send_byte(8'h91); send_byte(8'h12);
        for (int i = 0; i < TO - 1; i++) tick();
        check("to_not_early", 32'(err_pulses - base), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("to_one_pulse", 32'(err_pulses - base), 32'd1);
        check("to_idle_ready", 32'(in_ready), 32'd1);
        send_byte(8'hC0); tick();
        check("to_offsets_unchanged", offsets, 32'h0);
        send_byte(8'h91); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hC0); tick();
        check("to_offsets_after", offsets, 32'hABCD_0000);

        // Illegal commands: bad field, all-ones prefix, nonzero bits[3:1]
        base = err_pulses;
        send_byte(8'hF0); tick();
        send_byte(8'hB0); tick();
        send_byte(8'h82); tick();
        check("illegal_pulses", 32'(err_pulses - base), 32'd3);
        check("illegal_pending", 32'(pending), 32'd0);
        // C0 inside a packet is data; amp ch1 shadow persists across commits
        send_byte(8'h80); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hA1); send_byte(8'hC0); send_byte(8'h00);
        send_byte(8'hC0); tick();
        check("after_illegal_amps", amps, 32'h7FFF_1234);
        check("c0_as_data_pw", phasewords, 32'hC000_0040);

        // Commit with nothing pending re-applies the same values
        send_byte(8'hC0); tick();
        check("recommit_amps", amps, 32'h7FFF_1234);
        check("recommit_pending", 32'(pending), 32'd0);

        // Echo handshake with a stalled consumer
        out_ready = 1'b0;
        send_byte(8'hC0);
        tick();
`ifdef WAVE_PARAM_LOADER_ECHO_EN
        for (int i = 0; i < 5; i++) begin
            check("echo_valid_hold", 32'(out_valid), 32'd1);
            check("echo_data_hold", 32'(out_data), 32'hA5);
            check("echo_in_ready_low", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("echo_done_valid", 32'(out_valid), 32'd0);
        check("echo_done_ready", 32'(in_ready), 32'd1);
`else
        for (int i = 0; i < 5; i++) begin
            check("noecho_valid", 32'(out_valid), 32'd0);
            check("noecho_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        out_ready = 1'b1;
`endif

        // Reset in the middle of an amp ch0 packet
        send_byte(8'h80); send_byte(8'h12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_amps", amps, 32'h0);
        check("midrst_offsets", offsets, 32'h0);
        check("midrst_phasewords", phasewords, 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        send_byte(8'hC0); tick();
        check("midrst_commit_amps", amps, 32'h0);
        check("midrst_pending", 32'(pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
